uart_tx_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares the single UART transmitter byte input (tx_d / tx_d_valid path into the TX FIFO) among NUM_REQ on-chip requesters.
A requester is granted for a whole packet, delimited by a last flag, so bytes from different sources never interleave on the line.
An inactivity timeout releases a stalled grant.
It sits between the requesters and the UART register/TX FIFO interface.

---
 rtl/uart_tx_arbiter.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Packet-level round-robin arbiter that shares the UART TX byte input among
// NUM_REQ on-chip requesters. A requester owns the TX path for a whole packet
// (terminated by its last flag), so bytes from different sources never
// interleave. An inactivity timeout releases a grant whose owner has stalled.
//
// Handshake (both sides): a byte moves on a cycle where valid and ready are
// both high. Valid is not allowed to depend on ready. While a grant is held,
// the data/valid/ready path is purely combinational with no buffering:
// tx_d_o/tx_d_valid_o come from the granted requester and its ready bit is
// tx_d_ready_i.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   req_valid_i     per-requester byte valid
//   req_data_i      per-requester byte, requester k at [k*DATA_W +: DATA_W]
//   req_last_i      per-requester last-byte-of-packet flag (qualified by valid)
//   req_ready_o     per-requester byte accepted this cycle
//   req_mask_i      1 = requester eligible for new grants
//   tx_d_o          byte to UART TX path
//   tx_d_valid_o    byte valid to UART TX path
//   tx_d_ready_i    UART TX path can accept
//   grant_o         one-hot current grant, zero when idle
//   src_id_o        binary index of the granted requester, 0 when idle
//   busy_o          high while a grant is held (mirrors the LOCK state)
//   timeout_o       one-cycle pulse when a grant is released by timeout
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data_i,
  input  logic [NUM_REQ-1:0]           req_last_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  input  logic [NUM_REQ-1:0]           req_mask_i,
  output logic [DATA_W-1:0]            tx_d_o,
  output logic                         tx_d_valid_o,
  input  logic                         tx_d_ready_i,
  output logic [NUM_REQ-1:0]           grant_o,
  output logic [$clog2(NUM_REQ)-1:0]   src_id_o,
  output logic                         busy_o,
  output logic                         timeout_o
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   src_q, src_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [NUM_REQ-1:0] eligible;
  logic               found;
  logic [IDW-1:0]     pick;
  logic [IDW-1:0]     cand_idx;
  int                 cand;
  logic               xfer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      // Pointer at the last requester so requester 0 is searched first.
      ptr_q   <= IDW'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    tx_d_o       = '0;
    tx_d_valid_o = 1'b0;
    req_ready_o  = '0;
    timeout_o    = 1'b0;
    xfer         = 1'b0;
    found        = 1'b0;
    pick         = '0;
    cand         = 0;
    cand_idx     = '0;

    // Round-robin search starting one past the last served requester.
    eligible = req_valid_i & req_mask_i;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand     = (int'(ptr_q) + i + 1) % NUM_REQ;
      cand_idx = IDW'(cand);
      if (!found && eligible[cand_idx]) begin
        found = 1'b1;
        pick  = cand_idx;
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = LOCK;
          src_d   = pick;
          cnt_d   = '0;
        end
      end

      LOCK: begin
        tx_d_o              = req_data_i[int'(src_q)*DATA_W +: DATA_W];
        tx_d_valid_o        = req_valid_i[src_q];
        req_ready_o[src_q]  = tx_d_ready_i;
        xfer                = req_valid_i[src_q] & tx_d_ready_i;

        if (xfer) begin
          // A transfer always restarts the inactivity window, even on the
          // cycle the counter would otherwise have expired.
          cnt_d = '0;
          if (req_last_i[src_q]) begin
            state_d = IDLE;
            ptr_d   = src_q;
            src_d   = '0;
          end
        end else if (cnt_q == CNT_MAX) begin
          timeout_o = 1'b1;
          state_d   = IDLE;
          ptr_d     = src_q;
          src_d     = '0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Nothing is accepted or signalled while reset is being applied.
    if (rst) begin
      req_ready_o  = '0;
      tx_d_valid_o = 1'b0;
      timeout_o    = 1'b0;
    end
  end

  assign busy_o   = (state_q == LOCK);
  assign src_id_o = src_q;
  assign grant_o  = busy_o ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << src_q) : '0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter (NUM_REQ=4, DATA_W=8, TIMEOUT=8).
// Inputs change 2 time units after the rising edge; outputs are checked one
// unit later, well away from either clock edge. Expected values are hand
// derived and held in tables or written inline with each step.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [3:0]  req_mask;
  logic [7:0]  tx_d;
  logic        tx_d_valid;
  logic        tx_d_ready;
  logic [3:0]  grant;
  logic [1:0]  src_id;
  logic        busy;
  logic        timeout;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Packet-source model for the multi-requester tests: act = requester
  // presents data, pos = index of the byte it is offering (0 or 1).
  logic [3:0] act;
  logic [3:0] pos;

  // Fairness: grant and byte per cycle, starting from the first IDLE cycle.
  logic [3:0] fair_g [15] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0,
                              4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1};
  logic [7:0] fair_d [15] = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h10, 8'h11, 8'h00,
                              8'h20, 8'h21, 8'h00, 8'h30, 8'h31, 8'h00, 8'h00, 8'h01};

  // Mask 1010, switched to 1000 from cycle 8 (mid-packet of requester 1).
  logic [3:0] mask_g [14] = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h8, 4'h8, 4'h0,
                              4'h2, 4'h2, 4'h0, 4'h8, 4'h8, 4'h0, 4'h8};
  logic [7:0] mask_d [14] = '{8'h00, 8'h10, 8'h11, 8'h00, 8'h30, 8'h31, 8'h00,
                              8'h10, 8'h11, 8'h00, 8'h30, 8'h31, 8'h00, 8'h30};

  uart_tx_arbiter #(
    .NUM_REQ (NUM_REQ),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_last_i   (req_last),
    .req_ready_o  (req_ready),
    .req_mask_i   (req_mask),
    .tx_d_o       (tx_d),
    .tx_d_valid_o (tx_d_valid),
    .tx_d_ready_i (tx_d_ready),
    .grant_o      (grant),
    .src_id_o     (src_id),
    .busy_o       (busy),
    .timeout_o    (timeout)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Driver tasks
  task automatic drive_pkts();
    for (int k = 0; k < 4; k++) begin
      req_valid[k]         = act[k];
      req_data[k*8 +: 8]   = {4'(k), 3'b000, pos[k]};
      req_last[k]          = pos[k];
    end
  endtask

  task automatic set_req(input int k, input logic v, input logic [7:0] d, input logic l);
    req_valid[k]       = v;
    req_data[k*8 +: 8] = d;
    req_last[k]        = l;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] eg, input logic [3:0] er,
                            input logic ev, input logic [7:0] ed, input logic et);
    check({tag, " grant"},   grant,      eg);
    check({tag, " ready"},   req_ready,  er);
    check({tag, " valid"},   tx_d_valid, ev);
    check({tag, " data"},    tx_d,       ed);
    check({tag, " src"},     src_id,     idx_of(eg));
    check({tag, " busy"},    busy,       eg != 4'h0);
    check({tag, " timeout"}, timeout,    et);
  endtask

  // One cycle of the packet-source model with tx_d_ready held at 1.
  task automatic pkt_cycle(input string tag, input logic [3:0] eg, input logic [7:0] ed);
    drive_pkts();
    settle();
    check_outs(tag, eg, eg, eg != 4'h0, ed, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (req_ready[k] && req_valid[k]) pos[k] = ~pos[k];
    end
    tick();
  endtask

  initial begin
    // ---------------- reset ----------------
    rst        = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    req_mask   = 4'hF;
    tx_d_ready = 1'b1;
    act        = '0;
    pos        = '0;
    tick();
    tick();
    rst = 1'b0;
    settle();
    check_outs("reset", 4'h0, 4'h0, 1'b0, 8'h00, 1'b0);

    // ---------------- fairness ----------------
    act = 4'hF;
    pos = '0;
    for (int c = 0; c < 15; c++) begin
      pkt_cycle($sformatf("fair%0d", c), fair_g[c], fair_d[c]);
    end
    act = '0;
    drive_pkts();
    settle();
    check_outs("fair_end", 4'h0, 4'h0, 1'b0, 8'h00, 1'b0);
    tick();

    // ---------------- backpressure (requester 2) ----------------
    tx_d_ready = 1'b0;
    set_req(2, 1'b1, 8'hA5, 1'b0);
    settle();
    check_outs("bp_idle", 4'h0, 4'h0, 1'b0, 8'h00, 1'b0);
    tick();
    for (int s = 0; s < 5; s++) begin
      settle();
      check_outs($sformatf("bp_stall%0d", s), 4'h4, 4'h0, 1'b1, 8'hA5, 1'b0);
      tick();
    end
    tx_d_ready = 1'b1;
    settle();
    check_outs("bp_b0", 4'h4, 4'h4, 1'b1, 8'hA5, 1'b0);
    tick();
    set_req(2, 1'b1, 8'h5A, 1'b1);
    settle();
    check_outs("bp_b1", 4'h4, 4'h4, 1'b1, 8'h5A, 1'b0);
    tick();
    set_req(2, 1'b0, 8'h00, 1'b0);
    settle();
    check_outs("bp_end", 4'h0, 4'h0, 1'b0, 8'h00, 1'b0);
    tick();

    // ---------------- timeout (requester 1 stalls, 2 waiting) ----------------
    set_req(1, 1'b1, 8'h11, 1'b0);
    set_req(2, 1'b1, 8'h22, 1'b1);
    settle();
    check_outs("to_idle", 4'h0, 4'h0, 1'b0, 8'h00, 1'b0);
    tick();
    settle();
    check_outs("to_xfer", 4'h2, 4'h2, 1'b1, 8'h11, 1'b0);
    tick();
    set_req(1, 1'b0, 8'h11, 1'b0);
    for (int s = 1; s <= 8; s++) begin
      settle();
      check($sformatf("to_s%0d grant", s),   grant,   4'h2);
      check($sformatf("to_s%0d valid", s),   tx_d_valid, 1'b0);
      check($sformatf("to_s%0d timeout", s), timeout, (s == 8) ? 1'b1 : 1'b0);
      tick();
    end
    settle();
    check_outs("to_rel", 4'h0, 4'h0, 1'b0, 8'h00, 1'b0);
    tick();
    settle();
    check_outs("to_next", 4'h4, 4'h4, 1'b1, 8'h22, 1'b0);
    tick();
    set_req(2, 1'b0, 8'h00, 1'b0);
    settle();
    check_outs("to_end", 4'h0, 4'h0, 1'b0, 8'h00, 1'b0);
    tick();

    // ---------------- race: transfer at counter == TIMEOUT-1 ----------------
    tx_d_ready = 1'b0;
    set_req(3, 1'b1, 8'h33, 1'b0);
    settle();
    check_outs("race_idle", 4'h0, 4'h0, 1'b0, 8'h00, 1'b0);
    tick();
    for (int s = 0; s < 7; s++) begin
      settle();
      check($sformatf("race_st%0d timeout", s), timeout, 1'b0);
      tick();
    end
    tx_d_ready = 1'b1;
    settle();
    check_outs("race_hit", 4'h8, 4'h8, 1'b1, 8'h33, 1'b0);
    tick();
    tx_d_ready = 1'b0;
    for (int s = 1; s <= 8; s++) begin
      settle();
      check($sformatf("race_re%0d grant", s),   grant,   4'h8);
      check($sformatf("race_re%0d timeout", s), timeout, (s == 8) ? 1'b1 : 1'b0);
      tick();
    end
    set_req(3, 1'b0, 8'h00, 1'b0);
    tx_d_ready = 1'b1;
    settle();
    check_outs("race_end", 4'h0, 4'h0, 1'b0, 8'h00, 1'b0);
    tick();

    // ---------------- mask ----------------
    req_mask = 4'b1010;
    act      = 4'hF;
    pos      = '0;
    for (int c = 0; c < 14; c++) begin
      if (c == 8) req_mask = 4'b1000;
      pkt_cycle($sformatf("mask%0d", c), mask_g[c], mask_d[c]);
    end

    // ---------------- reset mid-packet ----------------
    rst = 1'b1;
    drive_pkts();
    settle();
    check("rst_cyc ready",   req_ready,  4'h0);
    check("rst_cyc valid",   tx_d_valid, 1'b0);
    check("rst_cyc timeout", timeout,    1'b0);
    tick();
    rst      = 1'b0;
    req_mask = 4'hF;
    pos      = '0;
    drive_pkts();
    settle();
    check_outs("rst_after", 4'h0, 4'h0, 1'b0, 8'h00, 1'b0);
    tick();
    settle();
    check_outs("rst_first", 4'h1, 4'h1, 1'b1, 8'h00, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
